// File: rtl/uart_tx_framer_if.sv
// Handshake and serial-line bundle for the UART transmit framer.
// The master side supplies bytes and config; the slave side drives the line.
interface uart_tx_framer_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      Data_Valid;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [PRESCALE_WIDTH-1:0] Prescale;
    logic                      TX_OUT;
    logic                      Busy;

    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output PAR_TYP,
        output Prescale,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  PAR_TYP,
        input  Prescale,
        output TX_OUT,
        output Busy
    );
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmitter: start, LSB-first data, optional parity, stop.
// Each bit lasts Prescale clocks; TX_OUT and Busy are registered.
module uart_tx_framer #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input logic             clk,
    input logic             rst,
    uart_tx_framer_if.slave bus
);
    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                    state;
    state_t                    state_nx;
    logic [PRESCALE_WIDTH-1:0] cnt;
    logic [PRESCALE_WIDTH-1:0] cnt_nx;
    logic [PRESCALE_WIDTH-1:0] pre_last;
    logic [BW-1:0]             bit_idx;
    logic [BW-1:0]             bit_nx;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      par_en_q;
    logic                      par_bit_q;
    logic                      tx_q;
    logic                      busy_q;
    logic                      tx_nx;
    logic                      busy_nx;
    logic                      data_bit;
    logic                      bit_done;
    logic                      accept;

    assign accept   = (state == IDLE) && bus.Data_Valid;
    assign bit_done = (cnt == pre_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            pre_last  <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            bit_idx <= bit_nx;
            tx_q    <= tx_nx;
            busy_q  <= busy_nx;
            if (accept) begin
                data_q    <= bus.P_DATA;
                par_en_q  <= bus.PAR_EN;
                par_bit_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
                // a zero prescale is stretched to one clock per bit
                pre_last  <= (bus.Prescale == '0) ? '0
                                                  : bus.Prescale - 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        bit_nx   = bit_idx;
        if (state != IDLE) begin
            cnt_nx = bit_done ? '0 : cnt + 1'b1;
        end
        unique case (state)
            IDLE: begin
                if (bus.Data_Valid) begin
                    state_nx = START;
                    cnt_nx   = '0;
                    bit_nx   = '0;
                end
            end
            START: begin
                if (bit_done) state_nx = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx == BIT_LAST) begin
                        bit_nx   = '0;
                        state_nx = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_nx = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) state_nx = STOP;
            end
            STOP: begin
                if (bit_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        data_bit = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_nx == BW'(i)) data_bit = data_q[i];
        end
    end

    // outputs are decoded from the next state so they register in step
    always_comb begin
        tx_nx   = 1'b1;
        busy_nx = (state_nx != IDLE);
        unique case (1'b1)
            state_nx == START:  tx_nx = 1'b0;
            state_nx == DATA:   tx_nx = data_bit;
            state_nx == PARITY: tx_nx = par_bit_q;
            default:            tx_nx = 1'b1;
        endcase
    end

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench: a frame-queue reference model is compared every cycle,
// and literal bit patterns and busy lengths pin each scenario.
module tb_uart_tx_framer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_framer_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();

    uart_tx_framer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;
    logic cur_tx   = 1'b1;
    logic cur_busy = 1'b0;
    logic [1:0] mq[$];

    // Model: on an idle cycle with a request, expand the whole frame
    // into one {tx,busy} entry per clock and replay it.
    always @(posedge clk or negedge rst) begin : model
        logic [1:0] e;
        int         eff;
        logic       fb[$];
        if (!rst) begin
            mq.delete();
            cur_tx   <= 1'b1;
            cur_busy <= 1'b0;
        end else if (mq.size() != 0) begin
            e = mq.pop_front();
            cur_tx   <= e[1];
            cur_busy <= e[0];
        end else if (!cur_busy && bus.Data_Valid) begin
            eff = (bus.Prescale == 0) ? 1 : int'(bus.Prescale);
            fb.delete();
            fb.push_back(1'b0);
            for (int i = 0; i < 8; i++) fb.push_back(bus.P_DATA[i]);
            if (bus.PAR_EN) fb.push_back((^bus.P_DATA) ^ bus.PAR_TYP);
            fb.push_back(1'b1);
            foreach (fb[k]) repeat (eff) mq.push_back({fb[k], 1'b1});
            e = mq.pop_front();
            cur_tx   <= e[1];
            cur_busy <= e[0];
        end else begin
            cur_tx   <= 1'b1;
            cur_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (bus.TX_OUT !== cur_tx || bus.Busy !== cur_busy) begin
                n_fail++;
                $display("FAIL model @%0t: tx=%b busy=%b, want tx=%b busy=%b",
                         $time, bus.TX_OUT, bus.Busy, cur_tx, cur_busy);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // one-cycle strobe, then scramble inputs to prove they were latched
    task automatic strobe(input logic [7:0] d, input logic pe,
                          input logic pt, input logic [5:0] ps);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.Prescale   = ps;
        bus.Data_Valid = 1'b1;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        bus.P_DATA     = ~d;
        bus.PAR_EN     = ~pe;
        bus.PAR_TYP    = ~pt;
        bus.Prescale   = 6'd3;
    endtask

    // Starts on the first busy cycle; samples each bit's first clock.
    task automatic capture(input string name, input int eff,
                           input int inj_c, input logic [7:0] inj_d,
                           input bit hold, output int bits,
                           output int bc);
        bit done = 1'b0;
        bits = 0;
        bc   = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!bus.Busy) begin
                done = 1'b1;
                break;
            end
            bc++;
            if (c % eff == 0 && c / eff < 16)
                bits = bits | (int'(bus.TX_OUT) << (c / eff));
            if (!hold) begin
                if (c == inj_c) begin
                    bus.Data_Valid = 1'b1;
                    bus.P_DATA     = inj_d;
                end else begin
                    bus.Data_Valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: busy=%b, want 0", name, bus.Busy);
        end
    endtask

    int bits;
    int bc;
    int gap;
    int cnt_busy;
    int cnt_low;

    initial begin
        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Prescale   = 6'd1;
        repeat (3) @(negedge clk);
        check("reset_tx", int'(bus.TX_OUT), 1);
        check("reset_busy", int'(bus.Busy), 0);
        rst    = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);

        strobe(8'hA5, 1'b1, 1'b0, 6'd8);
        capture("t1", 8, -1, 8'h00, 1'b0, bits, bc);
        check("t1_bits", bits, 32'h54A);
        check("t1_busy", bc, 88);
        check("t1_idle", int'(bus.TX_OUT), 1);

        strobe(8'hA5, 1'b1, 1'b1, 6'd8);
        capture("t2o", 8, -1, 8'h00, 1'b0, bits, bc);
        check("t2_odd_bits", bits, 32'h74A);
        check("t2_odd_busy", bc, 88);

        strobe(8'hA5, 1'b0, 1'b0, 6'd8);
        capture("t2n", 8, -1, 8'h00, 1'b0, bits, bc);
        check("t2_nopar_bits", bits, 32'h34A);
        check("t2_nopar_busy", bc, 80);

        strobe(8'h0F, 1'b0, 1'b0, 6'd16);
        capture("t3", 16, 69, 8'h3C, 1'b0, bits, bc);
        check("t3_bits", bits, 32'h21E);
        check("t3_busy", bc, 160);
        cnt_busy = 0;
        cnt_low  = 0;
        repeat (40) begin
            if (bus.Busy) cnt_busy++;
            if (!bus.TX_OUT) cnt_low++;
            @(negedge clk);
        end
        check("t3_no_busy", cnt_busy, 0);
        check("t3_no_low", cnt_low, 0);

        bus.P_DATA     = 8'h55;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Prescale   = 6'd4;
        bus.Data_Valid = 1'b1;
        @(negedge clk);
        bus.P_DATA = 8'hAA;
        capture("t4a", 4, -1, 8'h00, 1'b1, bits, bc);
        check("t4a_bits", bits, 32'h2AA);
        check("t4a_busy", bc, 40);
        check("t4_gap_tx", int'(bus.TX_OUT), 1);
        gap = 0;
        while (!bus.Busy && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        check("t4_gap", gap, 1);
        bus.Data_Valid = 1'b0;
        capture("t4b", 4, -1, 8'h00, 1'b0, bits, bc);
        check("t4b_bits", bits, 32'h354);
        check("t4b_busy", bc, 40);

        strobe(8'hC3, 1'b1, 1'b0, 6'd4);
        repeat (21) @(negedge clk);
        check("t5_mid_busy", int'(bus.Busy), 1);
        #2 rst = 1'b0;
        #1;
        check("t5_async_tx", int'(bus.TX_OUT), 1);
        check("t5_async_busy", int'(bus.Busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_no_resume", int'(bus.Busy), 0);
        strobe(8'hC3, 1'b1, 1'b0, 6'd4);
        capture("t5", 4, -1, 8'h00, 1'b0, bits, bc);
        check("t5_bits", bits, 32'h586);
        check("t5_busy", bc, 44);

        strobe(8'h81, 1'b1, 1'b0, 6'd0);
        capture("t6z", 1, -1, 8'h00, 1'b0, bits, bc);
        check("t6_ps0_bits", bits, 32'h502);
        check("t6_ps0_busy", bc, 11);
        strobe(8'h81, 1'b1, 1'b0, 6'd1);
        capture("t6o", 1, -1, 8'h00, 1'b0, bits, bc);
        check("t6_ps1_bits", bits, 32'h502);
        check("t6_ps1_busy", bc, 11);

        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
